i2c_word_master: RTL and testbench
==================================

Name: i2c_word_master

Overview:
- Single-clock I2C bus master that performs one complete 16-bit word transfer per request.
- Transfer sequence: START, 7-bit address + R/W, two data bytes MSB-first, STOP.
- Sits directly upstream of the team's I2C slave/target block and drives its SCL/SDA.
- Open-drain style outputs: line low when enable is asserted, released otherwise.

Parameters:
- CLK_DIV, 50, clk cycles per SCL quarter-period; SCL period = 4*CLK_DIV clk cycles; legal range 2..1023.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous reset, active-low
- start  input  1  request pulse; sampled only in IDLE
- rw  input  1  0 = write, 1 = read; captured with start
- adress  input  7  target address; captured with start
- data  input  16  write word; captured with start
- out  output  16  read word; updated at read completion
- busy  output  1  high from cycle after accepted start until done
- done  output  1  one-cycle pulse at end of STOP
- ack_err  output  1  sticky NACK flag for last transfer; cleared on next accepted start
- i_sda  input  1  sampled bus SDA
- i_scl  input  1  sampled bus SCL (used only with stretch feature)
- o_sda  output  1  constant 0
- o_scl  output  1  constant 0
- o_sda_en  output  1  1 = pull SDA low
- o_scl_en  output  1  1 = pull SCL low

Behaviour:
- Reset values: o_sda_en=0, o_scl_en=0 (bus released), busy=0, done=0, ack_err=0, out=16'h0000, state=IDLE, all counters 0.
- Quarter tick: divider counts 0..CLK_DIV-1 and emits a tick on wrap. Divider is held at 0 in IDLE.
- Each bit is four quarters:
  - Q0: SCL low, SDA updated.
  - Q1: SCL released.
  - Q2: SCL high, SDA sampled from i_sda on this tick.
  - Q3: SCL high, then driven low at end.
- State sequence:
  - IDLE -> START on start=1. Captures {adress, rw}, data; sets busy; clears ack_err.
  - START: SDA low while SCL high for 2 quarters, then SCL low.
  - ADDR: 8 bits, shifting {adress, rw}.
  - AACK: SDA released; sample ACK. If i_sda=1: ack_err=1 -> STOP.
  - BYTE1: write drives data[15:8]; read releases SDA and shifts sampled bits into out[15:8].
  - ACK1: write samples slave ACK (NACK -> ack_err=1 -> STOP); read drives ACK (SDA low).
  - BYTE2: same as BYTE1 for data[7:0] / out[7:0].
  - ACK2: write samples ACK; read drives NACK (SDA released). Both -> STOP.
  - STOP: SCL low with SDA low, then SCL released, then SDA released 1 quarter later. done pulses on the next cycle, busy=0, back to IDLE.
- Bit counter is 3 bits, counting 7 down to 0; wraps to the ACK state.
- out is updated only when a read completes with no ack_err. An aborted read leaves out unchanged.
- start while busy: ignored, no queueing.
- start and a reset release in the same cycle: start is ignored.
- Reset asserted mid-transfer: all outputs return to reset values asynchronously. No STOP is generated.
- Write transfer with no stretching = 1 START + 27 bit periods + 1 STOP.

Optional Feature:
- Macro: I2C_CLK_STRETCH_EN.
- Defined: in Q1, the divider holds until i_scl reads 1. Slave stretching extends the low phase by any number of cycles. A 2-flop synchronizer is used on i_scl and i_sda.
- Not defined: i_scl is ignored. Timing is purely divider-driven. i_sda is sampled through a single flop.

Test Plan:
- Write: CLK_DIV=4, start with adress=7'h27, rw=0, data=16'hA55A, slave ACKs all bytes -> bus shows START, bytes 8'h4E, 8'hA5, 8'h5A, STOP; done pulses once; ack_err=0; busy high for exactly the transfer.
- Address NACK: adress=7'h11, no device responds -> bytes 8'h22 then STOP directly; ack_err=1; done pulses; out unchanged.
- Read: adress=7'h27, rw=1, slave model returns 16'h1234 -> address byte 8'h4F; master ACKs after 8'h12 and NACKs after 8'h34; out=16'h1234 at done.
- Start while busy: second start pulse mid-transfer -> ignored; exactly one done pulse; captured data unchanged.
- Reset mid-transfer: drive rst=0 during BYTE1 -> o_sda_en=0, o_scl_en=0, busy=0 in the same cycle; next start after release completes normally.
- With I2C_CLK_STRETCH_EN: slave holds SCL low 37 cycles in BYTE2 -> transfer completes with correct bits; SCL high time after release is still 2*CLK_DIV.

Source files
------------

// File: rtl/i2c_word_master.sv
`timescale 1ns/1ps
// i2c_word_master - single-clock I2C master that moves one 16-bit word
// per request: START, 7-bit address + R/W, two data bytes MSB first, STOP.
// Optional define I2C_CLK_STRETCH_EN: Q1 waits for SCL to read high
// (slave clock stretching) and i_scl/i_sda pass through 2-flop syncs;
// without it i_scl is ignored and i_sda is sampled through one flop.
// Ports: clk, rst (async, active-low); start/rw/adress/data request;
// out read word; busy; done pulse; ack_err sticky NACK flag;
// i_sda/i_scl bus sense; o_sda/o_scl tied 0; o_sda_en/o_scl_en pull low.
module i2c_word_master #(
    parameter int CLK_DIV = 50
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        rw,
    input  logic [6:0]  adress,
    input  logic [15:0] data,
    output logic [15:0] out,
    output logic        busy,
    output logic        done,
    output logic        ack_err,
    input  logic        i_sda,
    input  logic        i_scl,
    output logic        o_sda,
    output logic        o_scl,
    output logic        o_sda_en,
    output logic        o_scl_en
);

    typedef enum logic [3:0] {
        IDLE, START, ADDR, AACK, BYTE1, ACK1, BYTE2, ACK2, STOP
    } state_t;

    localparam logic [9:0] DIV_LAST = 10'(CLK_DIV - 1);

    state_t      state, state_n;
    logic [9:0]  cnt;
    logic [1:0]  q;
    logic [2:0]  bitcnt;
    logic [7:0]  addr_q;
    logic [15:0] wdata;
    logic [15:0] rx;
    logic        smp;
    logic        armed;
    logic        sda_s;
    logic        scl_ok;
    logic        tick;
    logic        bit_end;
    logic        nack;
    logic        rd;
    logic        sda_en_c;
    logic        scl_en_c;

`ifdef I2C_CLK_STRETCH_EN
    logic [1:0] sda_sync;
    logic [1:0] scl_sync;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sda_sync <= 2'b11;
            scl_sync <= 2'b11;
        end else begin
            sda_sync <= {sda_sync[0], i_sda};
            scl_sync <= {scl_sync[0], i_scl};
        end
    end

    assign sda_s  = sda_sync[1];
    assign scl_ok = scl_sync[1];
`else
    logic sda_q;
    logic unused_scl;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) sda_q <= 1'b1;
        else      sda_q <= i_sda;
    end

    assign sda_s      = sda_q;
    assign scl_ok     = 1'b1;
    assign unused_scl = i_scl;
`endif

    assign rd = addr_q[0];

    // Q1 may be held at its last count until the bus SCL reads high.
    assign tick = (state != IDLE) && (cnt == DIV_LAST)
                  && !((q == 2'd1) && !scl_ok);
    assign bit_end = tick && (q == 2'd3);

    // Only slave-driven ACK slots can abort the transfer.
    assign nack = smp && ((state == AACK)
                  || (!rd && (state == ACK1 || state == ACK2)));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_n;
    end

    always_comb begin
        state_n  = state;
        sda_en_c = 1'b0;
        scl_en_c = 1'b0;
        unique case (state)
            IDLE: begin
                if (start && armed) state_n = START;
            end
            START: begin
                sda_en_c = 1'b1;
                if (tick && q == 2'd1) state_n = ADDR;
            end
            ADDR: begin
                scl_en_c = (q == 2'd0);
                sda_en_c = ~addr_q[bitcnt];
                if (bit_end && bitcnt == 3'd0) state_n = AACK;
            end
            AACK: begin
                scl_en_c = (q == 2'd0);
                if (bit_end) state_n = nack ? STOP : BYTE1;
            end
            BYTE1: begin
                scl_en_c = (q == 2'd0);
                sda_en_c = ~rd & ~wdata[{1'b1, bitcnt}];
                if (bit_end && bitcnt == 3'd0) state_n = ACK1;
            end
            ACK1: begin
                scl_en_c = (q == 2'd0);
                sda_en_c = rd;
                if (bit_end) state_n = nack ? STOP : BYTE2;
            end
            BYTE2: begin
                scl_en_c = (q == 2'd0);
                sda_en_c = ~rd & ~wdata[{1'b0, bitcnt}];
                if (bit_end && bitcnt == 3'd0) state_n = ACK2;
            end
            ACK2: begin
                scl_en_c = (q == 2'd0);
                if (bit_end) state_n = STOP;
            end
            STOP: begin
                // q==2 is a single-cycle step with both lines released.
                scl_en_c = (q == 2'd0);
                sda_en_c = (q != 2'd2);
                if (q == 2'd2) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt     <= '0;
            q       <= '0;
            bitcnt  <= '0;
            addr_q  <= '0;
            wdata   <= '0;
            rx      <= '0;
            smp     <= 1'b0;
            armed   <= 1'b0;
            out     <= '0;
            done    <= 1'b0;
            ack_err <= 1'b0;
        end else begin
            // armed blocks a start seen on the first edge after reset.
            armed <= 1'b1;
            done  <= 1'b0;
            if (state == IDLE) begin
                cnt <= '0;
                q   <= '0;
                if (start && armed) begin
                    addr_q  <= {adress, rw};
                    wdata   <= data;
                    ack_err <= 1'b0;
                    bitcnt  <= 3'd7;
                end
            end else begin
                if (tick) begin
                    cnt <= '0;
                    q   <= (state == START && q == 2'd1) ? 2'd0 : q + 2'd1;
                end else if (cnt != DIV_LAST) begin
                    cnt <= cnt + 10'd1;
                end
                if (tick && q == 2'd2) begin
                    smp <= sda_s;
                    if (rd && (state == BYTE1 || state == BYTE2))
                        rx <= {rx[14:0], sda_s};
                end
                if (bit_end && (state == ADDR || state == BYTE1
                                || state == BYTE2))
                    bitcnt <= bitcnt - 3'd1;
                if (bit_end && nack) ack_err <= 1'b1;
                if (state == STOP && q == 2'd2) begin
                    done <= 1'b1;
                    if (rd && !ack_err) out <= rx;
                end
            end
        end
    end

    assign busy     = (state != IDLE);
    assign o_sda    = 1'b0;
    assign o_scl    = 1'b0;
    assign o_sda_en = sda_en_c;
    assign o_scl_en = scl_en_c;

endmodule

// File: tb/tb_i2c_word_master.sv
`timescale 1ns/1ps
// tb_i2c_word_master - directed bench with a behavioural I2C slave at
// address 7'h27 that records bus bytes/acks and answers read requests.
module tb_i2c_word_master;

    localparam int DIV    = 4;
    // 2 START quarters + 27 bits * 4 + STOP 2 quarters, 4 clk each, +1
    localparam int T_WORD = 449;
    // 2 START quarters + 9 bits * 4 + STOP 2 quarters, 4 clk each, +1
    localparam int T_NACK = 161;

    logic        clk;
    logic        rst;
    logic        start;
    logic        rw;
    logic [6:0]  adress;
    logic [15:0] data;
    logic [15:0] out;
    logic        busy;
    logic        done;
    logic        ack_err;
    logic        o_sda;
    logic        o_scl;
    logic        o_sda_en;
    logic        o_scl_en;
    logic        slv_sda_low;
    logic        slv_scl_low;
    logic        bus_sda;
    logic        bus_scl;

    assign bus_sda = ~(o_sda_en | slv_sda_low);
    assign bus_scl = ~(o_scl_en | slv_scl_low);

    i2c_word_master #(.CLK_DIV(DIV)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .rw       (rw),
        .adress   (adress),
        .data     (data),
        .out      (out),
        .busy     (busy),
        .done     (done),
        .ack_err  (ack_err),
        .i_sda    (bus_sda),
        .i_scl    (bus_scl),
        .o_sda    (o_sda),
        .o_scl    (o_scl),
        .o_sda_en (o_sda_en),
        .o_scl_en (o_scl_en)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests;
    int n_fail;

    int         rises;
    int         nbytes;
    int         stops;
    int         busy_cyc;
    int         done_cnt;
    int         stretch_cnt;
    int         hi_run;
    int         hi_len;
    logic       in_xfer;
    logic       prev_scl;
    logic       prev_sda;
    logic       s_rw;
    logic       addr_hit;
    logic       stretch_arm;
    logic       after_stretch;
    logic [7:0] sh;
    logic [7:0] mbytes [4];
    logic       macks [4];
    logic [15:0] rdata;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
        end
    endtask

    task automatic reset_slave();
        in_xfer     = 1'b0;
        rises       = 0;
        nbytes      = 0;
        stops       = 0;
        slv_sda_low = 1'b0;
        s_rw        = 1'b0;
        addr_hit    = 1'b0;
        busy_cyc    = 0;
        done_cnt    = 0;
        for (int i = 0; i < 4; i++) begin
            mbytes[i] = 8'hxx;
            macks[i]  = 1'bx;
        end
    endtask

    // Slave + bus monitor, sampling away from the DUT's active edge.
    initial begin
        int pos;
        int k;
        prev_scl = 1'b1;
        prev_sda = 1'b1;
        hi_run   = 0;
        sh       = 8'h00;
        forever begin
            @(negedge clk);
            if (busy) busy_cyc++;
            if (done) done_cnt++;
            if (stretch_cnt > 0) begin
                stretch_cnt--;
                if (stretch_cnt == 0) begin
                    slv_scl_low   = 1'b0;
                    after_stretch = 1'b1;
                end
            end
            pos = rises % 9;
            k   = rises / 9;
            if (prev_scl && bus_scl && prev_sda && !bus_sda) begin
                in_xfer = 1'b1;
                rises   = 0;
            end else if (prev_scl && bus_scl && !prev_sda && bus_sda) begin
                if (in_xfer) stops++;
                in_xfer     = 1'b0;
                slv_sda_low = 1'b0;
            end else if (in_xfer && !prev_scl && bus_scl) begin
                if (pos < 8) sh = {sh[6:0], bus_sda};
                if (pos == 7 && k < 4) begin
                    mbytes[k] = sh;
                    nbytes    = k + 1;
                    if (k == 0) begin
                        s_rw     = sh[0];
                        addr_hit = (sh[7:1] == 7'h27);
                    end
                end
                if (pos == 8 && k < 4) macks[k] = bus_sda;
                rises++;
            end else if (in_xfer && prev_scl && !bus_scl) begin
                if (after_stretch) begin
                    hi_len        = hi_run;
                    after_stretch = 1'b0;
                end
                slv_sda_low = 1'b0;
                if (pos == 8)
                    slv_sda_low = addr_hit && (k == 0 || !s_rw);
                else if (s_rw && addr_hit && (k == 1 || k == 2))
                    slv_sda_low = ~rdata[(k == 1 ? 15 : 7) - pos];
                if (stretch_arm && k == 2 && pos == 0) begin
                    slv_scl_low = 1'b1;
                    stretch_cnt = 37;
                    stretch_arm = 1'b0;
                end
            end
            hi_run   = bus_scl ? hi_run + 1 : 0;
            prev_scl = bus_scl;
            prev_sda = bus_sda;
        end
    end

    task automatic kick(input logic r, input logic [6:0] a,
                        input logic [15:0] d);
        reset_slave();
        @(negedge clk);
        rw     = r;
        adress = a;
        data   = d;
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (done !== 1'b1 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_done"}, 32'(n < 2000), 32'd1);
        repeat (4) @(negedge clk);
    endtask

    initial begin
        int n;
        n_tests       = 0;
        n_fail        = 0;
        rst           = 1'b0;
        start         = 1'b0;
        rw            = 1'b0;
        adress        = 7'h00;
        data          = 16'h0000;
        slv_scl_low   = 1'b0;
        stretch_cnt   = 0;
        stretch_arm   = 1'b0;
        after_stretch = 1'b0;
        hi_len        = -1;
        rdata         = 16'h1234;
        reset_slave();
        repeat (3) @(negedge clk);
        chk("rst_sda_en", 32'(o_sda_en), 32'd0);
        chk("rst_scl_en", 32'(o_scl_en), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_ackerr", 32'(ack_err), 32'd0);
        chk("rst_out", 32'(out), 32'd0);
        chk("o_sda_o_scl", 32'({o_sda, o_scl}), 32'd0);
        rst = 1'b1;
        repeat (3) @(negedge clk);

        // plain write, slave acks everything
        kick(1'b0, 7'h27, 16'hA55A);
        chk("wr_busy_on", 32'(busy), 32'd1);
        wait_done("wr");
        chk("wr_addr", 32'(mbytes[0]), 32'h4E);
        chk("wr_b1", 32'(mbytes[1]), 32'hA5);
        chk("wr_b2", 32'(mbytes[2]), 32'h5A);
        chk("wr_acks", 32'({macks[0], macks[1], macks[2]}), 32'd0);
        chk("wr_stop", 32'(stops), 32'd1);
        chk("wr_ndone", 32'(done_cnt), 32'd1);
        chk("wr_busy_len", 32'(busy_cyc), 32'(T_WORD));
        chk("wr_ackerr", 32'(ack_err), 32'd0);
        chk("wr_out", 32'(out), 32'd0);

        // read: master acks first byte, nacks second
        kick(1'b1, 7'h27, 16'h0000);
        wait_done("rd");
        chk("rd_addr", 32'(mbytes[0]), 32'h4F);
        chk("rd_b1", 32'(mbytes[1]), 32'h12);
        chk("rd_b2", 32'(mbytes[2]), 32'h34);
        chk("rd_acks", 32'({macks[0], macks[1], macks[2]}), 32'b001);
        chk("rd_out", 32'(out), 32'h1234);
        chk("rd_ackerr", 32'(ack_err), 32'd0);
        chk("rd_busy_len", 32'(busy_cyc), 32'(T_WORD));

        // address nobody answers
        kick(1'b0, 7'h11, 16'hFFFF);
        wait_done("nk");
        chk("nk_addr", 32'(mbytes[0]), 32'h22);
        chk("nk_ack", 32'(macks[0]), 32'd1);
        chk("nk_nbytes", 32'(nbytes), 32'd1);
        chk("nk_stop", 32'(stops), 32'd1);
        chk("nk_ackerr", 32'(ack_err), 32'd1);
        chk("nk_ndone", 32'(done_cnt), 32'd1);
        chk("nk_busy_len", 32'(busy_cyc), 32'(T_NACK));
        chk("nk_out", 32'(out), 32'h1234);

        // second start while busy is dropped
        kick(1'b0, 7'h27, 16'hC33C);
        chk("bs_ackerr_clr", 32'(ack_err), 32'd0);
        repeat (100) @(negedge clk);
        rw     = 1'b1;
        adress = 7'h55;
        data   = 16'h1111;
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        wait_done("bs");
        chk("bs_addr", 32'(mbytes[0]), 32'h4E);
        chk("bs_b1", 32'(mbytes[1]), 32'hC3);
        chk("bs_b2", 32'(mbytes[2]), 32'h3C);
        chk("bs_ndone", 32'(done_cnt), 32'd1);
        chk("bs_busy_len", 32'(busy_cyc), 32'(T_WORD));
        repeat (20) @(negedge clk);
        chk("bs_idle", 32'(busy), 32'd0);

        // reset in the middle of BYTE1
        kick(1'b0, 7'h27, 16'hBEEF);
        n = 0;
        while (rises < 12 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk("mr_reach", 32'(n < 1000), 32'd1);
        #2 rst = 1'b0;
        #1;
        chk("mr_sda_en", 32'(o_sda_en), 32'd0);
        chk("mr_scl_en", 32'(o_scl_en), 32'd0);
        chk("mr_busy", 32'(busy), 32'd0);
        chk("mr_out", 32'(out), 32'd0);
        @(negedge clk);
        rw     = 1'b0;
        adress = 7'h27;
        data   = 16'h5555;
        start  = 1'b1;
        rst    = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        repeat (3) @(negedge clk);
        chk("rr_start_ign", 32'({busy, done}), 32'd0);

        kick(1'b0, 7'h27, 16'h0FF0);
        wait_done("pr");
        chk("pr_addr", 32'(mbytes[0]), 32'h4E);
        chk("pr_b1", 32'(mbytes[1]), 32'h0F);
        chk("pr_b2", 32'(mbytes[2]), 32'hF0);
        chk("pr_acks", 32'({macks[0], macks[1], macks[2]}), 32'd0);
        chk("pr_ndone", 32'(done_cnt), 32'd1);
        chk("pr_ackerr", 32'(ack_err), 32'd0);

`ifdef I2C_CLK_STRETCH_EN
        // slave holds SCL low 37 cycles at the first BYTE2 bit
        stretch_arm = 1'b1;
        hi_len      = -1;
        kick(1'b0, 7'h27, 16'h3CA5);
        wait_done("st");
        chk("st_addr", 32'(mbytes[0]), 32'h4E);
        chk("st_b1", 32'(mbytes[1]), 32'h3C);
        chk("st_b2", 32'(mbytes[2]), 32'hA5);
        chk("st_ndone", 32'(done_cnt), 32'd1);
        chk("st_longer", 32'(busy_cyc > T_WORD), 32'd1);
        chk("st_hi_time", 32'(hi_len >= 2 * DIV && hi_len <= 2 * DIV + 3),
            32'd1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
